rr_arbiter_hold: RTL
====================

Name: rr_arbiter_hold

Overview:
- Registered, parametrised request arbiter. Successor to the combinational fixed-priority grant encoder.
- Adds round-robin fairness with a runtime fixed-priority fallback mode.
- Adds a grant-hold handshake: the grant persists until the downstream acknowledges or the requester withdraws.
- Adds a hold-timeout watchdog. Sits between SIZE requesters and one shared resource, such as a bus or memory port.

Parameters:
- SIZE, 8, number of requesters; legal 2..32.
- IDX_W, $clog2(SIZE), width of the encoded grant index.
- HOLD_MAX, 16, max consecutive cycles a grant may stay un-acknowledged before forced revoke; legal 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- requests  input  SIZE  request vector; bit i = requester i wants the resource
- fixed_mode  input  1  1 = fixed priority (lowest index wins); 0 = round-robin
- grant_ack  input  1  downstream completes the transfer for the current grant this cycle
- grants  output  SIZE  registered one-hot grant; all zero when idle
- grant_valid  output  1  registered; 1 exactly when grants is non-zero
- grant_index  output  IDX_W  binary index of the granted requester; 0 when idle
- timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset (async assert, sync release): grants=0, grant_valid=0, grant_index=0, timeout=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- FSM has two states: IDLE and GRANT.
- Winner selection (combinational, used on state entry):
  - fixed_mode=1: lowest set bit of requests.
  - fixed_mode=0: first set bit searching from rr_ptr upward, wrapping SIZE-1 -> 0.
- IDLE: if |requests, register winner at next edge, go to GRANT, hold_cnt=0. Latency from request to grant is 1 cycle. Otherwise stay.
- GRANT, evaluated each cycle in priority order:
  1. grant_ack=1:
     - Transfer done; rr_ptr = (grant_index+1) mod SIZE.
     - Re-arbitrate in the same edge over requests, with the current grant bit masked only if its request is also dropping.
     - A new winner is granted at the next edge with no idle bubble (back-to-back). The holder may win again only in fixed_mode or when it is the sole requester.
     - If there is no other request, go to IDLE.
  2. requests[grant_index]=0 with no ack: withdraw. Clear the grant, rr_ptr = grant_index+1, go to IDLE (1 bubble cycle).
  3. hold_cnt == HOLD_MAX-1 with no ack: revoke the grant, pulse timeout for 1 cycle, rr_ptr = grant_index+1, go to IDLE.
  4. Otherwise: hold grants unchanged, hold_cnt++.
- grant_ack while grant_valid=0 is ignored.
- fixed_mode changes take effect only at the next selection; they never pre-empt a held grant.
- rr_ptr wrap: (SIZE-1)+1 -> 0. Non-power-of-2 SIZE must never produce an index >= SIZE.
- Outputs are glitch-free: every output is a flop.
- Invariant checked in bench: grants is one-hot or zero, and grant_valid == |grants.

Test Plan:
- Reset/idle: rst_n low mid-grant -> grants=0, grant_valid=0 asynchronously; after release with requests=0 -> outputs stay 0.
- Round-robin: SIZE=8, fixed_mode=0, requests=8'hFF held, grant_ack=1 every cycle -> grant_index sequence 0,1,...,7,0 with no idle cycles.
- Fixed priority: fixed_mode=1, requests=8'b1010_0100, ack every cycle -> grant_index stays 2 each cycle; drop bit2 -> 5, then 7.
- Hold/withdraw: grant to 3, no ack, drop requests[3] at cycle 4 -> grants=0 next cycle, timeout=0; next grant from search start 4.
- Timeout: HOLD_MAX=16, grant to 1 held, no ack -> grant present for exactly 16 cycles, then grants=0 with timeout=1 for one cycle; requester 1 still requesting with requester 6 also requesting -> 6 granted next.
- Wrap/odd size: SIZE=5, requests=5'b10001, ack each cycle -> grant_index alternates 0,4,0,4; never an index >= 5.

Source files
------------

// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: registered round-robin/fixed-priority arbiter with grant hold, ack handshake and hold-timeout watchdog
//   clk, rst_n              : clock, asynchronous active-low reset
//   requests[SIZE]          : request vector, bit i = requester i
//   fixed_mode              : 1 = lowest index wins, 0 = round-robin from rr_ptr
//   grant_ack               : downstream completes the current grant this cycle
//   grants[SIZE]            : registered one-hot grant, zero when idle
//   grant_valid             : registered, 1 exactly when grants is non-zero
//   grant_index[IDX_W]      : binary index of the granted requester, 0 when idle
//   timeout                 : one-cycle pulse when the watchdog revokes a grant
module rr_arbiter_hold #(
    parameter int SIZE     = 8,
    parameter int IDX_W    = $clog2(SIZE),
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SIZE-1:0]  requests,
    input  logic             fixed_mode,
    input  logic             grant_ack,
    output logic [SIZE-1:0]  grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_index,
    output logic             timeout
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    state_t           state_q, state_d;
    logic [SIZE-1:0]  grants_q, grants_d;
    logic [IDX_W-1:0] idx_q, idx_d, rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] next_ptr, start, win_idx;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d, win_found;
    int               pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grants_q   <= '0;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grants_q   <= grants_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // explicit wrap keeps the pointer below SIZE for non-power-of-2 sizes
    assign next_ptr = (idx_q == IDX_W'(SIZE - 1)) ? '0 : idx_q + 1'b1;
    // on ack the search already starts past the holder, giving back-to-back fairness
    assign start    = (state_q == GRANT && grant_ack) ? next_ptr : rr_ptr_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        for (int k = 0; k < SIZE; k++) begin
            pos = fixed_mode ? k : (int'(start) + k) % SIZE;
            if (!win_found && requests[pos]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(pos);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grants_d   = grants_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == IDLE || grant_ack) begin
            if (state_q == GRANT) rr_ptr_d = next_ptr;
            state_d    = win_found ? GRANT : IDLE;
            grants_d   = win_found ? (SIZE'(1) << win_idx) : '0;
            idx_d      = win_found ? win_idx : '0;
            hold_cnt_d = '0;
        end else if (!requests[idx_q] || hold_cnt_q == 8'(HOLD_MAX - 1)) begin
            timeout_d  = requests[idx_q];
            state_d    = IDLE;
            grants_d   = '0;
            idx_d      = '0;
            rr_ptr_d   = next_ptr;
            hold_cnt_d = '0;
        end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_comb begin
        grants      = grants_q;
        grant_valid = (state_q == GRANT);
        grant_index = idx_q;
        timeout     = timeout_q;
    end
endmodule
